// File: rtl/temp_cal_pkg.sv
// Shared types and constants for the temperature-calibration sequencer.
package temp_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CNV,
    ADD0,
    FETCH1,
    MUL1,
    FETCH2,
    ADD2
  } state_e;

  localparam logic [1:0] NV_C0 = 2'd0;
  localparam logic [1:0] NV_C1 = 2'd1;
  localparam logic [1:0] NV_C2 = 2'd2;

  localparam int unsigned TO_CNT_W = 16;

endpackage

// File: rtl/temp_cal_ctrl_if.sv
// Control/datapath bundle between the calibration sequencer (master) and its environment (slave).
interface temp_cal_ctrl_if;

  logic        strt;
  logic        cnv_cmplt;
  logic        a2d_strt;
  logic [1:0]  nv_addr;
  logic        selA2D;
  logic        selCoeff;
  logic        selMult;
  logic        enTmp;
  logic [15:0] dst;
  logic        rdy;
  logic [15:0] result;
  logic        result_vld;
  logic        err;

  modport master (
    input  strt, cnv_cmplt, dst,
    output a2d_strt, nv_addr, selA2D, selCoeff, selMult, enTmp, rdy, result, result_vld, err
  );

  modport slave (
    output strt, cnv_cmplt, dst,
    input  a2d_strt, nv_addr, selA2D, selCoeff, selMult, enTmp, rdy, result, result_vld, err
  );

endinterface

// File: rtl/cal_timeout_cnt.sv
// WAIT_CNV cycle counter; o_tc flags the Limit-th enabled cycle since the last clear.
module cal_timeout_cnt #(
  parameter int unsigned Width = 16,
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == Width'(Limit - 1));

endmodule

// File: rtl/temp_cal_ctrl.sv
// Sequencer driving the datapath to compute Temp = ((a2d + C0) * C1) + C2 and capture the result.
// Optional conversion timeout enabled by defining TEMP_CAL_TIMEOUT_EN.
module temp_cal_ctrl
  import temp_cal_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  temp_cal_ctrl_if.master bus
);

  state_e      r_state, w_state_nxt;
  logic        r_a2d_strt;
  logic [1:0]  r_nv_addr;
  logic [15:0] r_result;
  logic        r_result_vld;
  logic        r_err;

  logic w_start, w_cmplt_ok, w_tc, w_timeout;
  logic w_sel_a2d, w_sel_coeff, w_sel_mult, w_en_tmp;

  assign w_start = (r_state == IDLE) && bus.strt;
  // The first WAIT_CNV cycle may still see cnv_cmplt from a previous conversion.
  assign w_cmplt_ok = bus.cnv_cmplt && !r_a2d_strt;

`ifdef TEMP_CAL_TIMEOUT_EN
  cal_timeout_cnt #(
    .Width (TO_CNT_W),
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (r_state == WAIT_CNV),
    .o_tc  (w_tc)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_tc = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_sel_a2d   = 1'b0;
    w_sel_coeff = 1'b0;
    w_sel_mult  = 1'b0;
    w_en_tmp    = 1'b0;
    unique case (r_state)
      IDLE:     if (bus.strt) w_state_nxt = WAIT_CNV;
      WAIT_CNV: begin
        if (w_cmplt_ok) begin
          w_state_nxt = ADD0;
        end else if (w_tc) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      ADD0: begin
        w_sel_a2d   = 1'b1;
        w_sel_coeff = 1'b1;
        w_en_tmp    = 1'b1;
        w_state_nxt = FETCH1;
      end
      FETCH1:   w_state_nxt = MUL1;
      MUL1: begin
        w_sel_mult  = 1'b1;
        w_en_tmp    = 1'b1;
        w_state_nxt = FETCH2;
      end
      FETCH2:   w_state_nxt = ADD2;
      ADD2: begin
        w_sel_coeff = 1'b1;
        w_en_tmp    = 1'b1;
        w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a2d_strt   <= 1'b0;
      r_nv_addr    <= NV_C0;
      r_result     <= 16'h0000;
      r_result_vld <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_a2d_strt   <= w_start;
      r_result_vld <= (r_state == ADD2);
      r_err        <= w_timeout;
      // Address moves one state ahead so the coefficient is valid when the datapath uses it.
      if (r_state == ADD0) r_nv_addr <= NV_C1;
      if (r_state == MUL1) r_nv_addr <= NV_C2;
      if (r_state == ADD2) begin
        r_nv_addr <= NV_C0;
        r_result  <= bus.dst;
      end
    end
  end

  assign bus.a2d_strt   = r_a2d_strt;
  assign bus.nv_addr    = r_nv_addr;
  assign bus.selA2D     = w_sel_a2d;
  assign bus.selCoeff   = w_sel_coeff;
  assign bus.selMult    = w_sel_mult;
  assign bus.enTmp      = w_en_tmp;
  assign bus.rdy        = (r_state == IDLE);
  assign bus.result     = r_result;
  assign bus.result_vld = r_result_vld;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_temp_cal_ctrl.sv
// Bench for temp_cal_ctrl: timestamp-based reference model, directed scenarios and random traffic.
// Define TEMP_CAL_TIMEOUT_EN to also exercise the conversion timeout (TIMEOUT_CYCLES = 8).
module tb_temp_cal_ctrl;

`ifdef TEMP_CAL_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic clk = 1'b0;
  logic rst;

  temp_cal_ctrl_if bus_if ();

  temp_cal_ctrl #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Model: ws = cycle WAIT_CNV began (-1 none), acc = cycle cnv_cmplt was accepted.
  int t, ws, acc, err_at, base;
  logic [15:0] m_result;
  int n_vec, n_err;
  bit chk_en;
  logic [31:0] m_en, m_a2d, m_vld, m_nv1, m_nv2, m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endfunction

  function automatic bit run_at(int k);
    return (acc >= 0) && (t == acc + k);
  endfunction

  function automatic bit exp_rdy();
    return !(ws >= 0) && !((acc >= 0) && (t >= acc + 1) && (t <= acc + 5));
  endfunction

  task automatic compare_outputs();
    int rel;
    logic [1:0] e_nv;
    e_nv = (run_at(2) || run_at(3)) ? 2'd1 : ((run_at(4) || run_at(5)) ? 2'd2 : 2'd0);
    check("rdy",        {31'd0, bus_if.rdy},        {31'd0, exp_rdy()});
    check("a2d_strt",   {31'd0, bus_if.a2d_strt},   {31'd0, (ws >= 0) && (t == ws)});
    check("enTmp",      {31'd0, bus_if.enTmp},      {31'd0, run_at(1) || run_at(3) || run_at(5)});
    check("selA2D",     {31'd0, bus_if.selA2D},     {31'd0, run_at(1)});
    check("selCoeff",   {31'd0, bus_if.selCoeff},   {31'd0, run_at(1) || run_at(5)});
    check("selMult",    {31'd0, bus_if.selMult},    {31'd0, run_at(3)});
    check("nv_addr",    {30'd0, bus_if.nv_addr},    {30'd0, e_nv});
    check("result_vld", {31'd0, bus_if.result_vld}, {31'd0, run_at(6)});
    check("result",     {16'd0, bus_if.result},     {16'd0, m_result});
    check("err",        {31'd0, bus_if.err},        {31'd0, t == err_at});
    rel = t - base;
    if (rel >= 0 && rel < 32) begin
      if (bus_if.enTmp === 1'b1)      m_en[rel]  = 1'b1;
      if (bus_if.a2d_strt === 1'b1)   m_a2d[rel] = 1'b1;
      if (bus_if.result_vld === 1'b1) m_vld[rel] = 1'b1;
      if (bus_if.nv_addr === 2'd1)    m_nv1[rel] = 1'b1;
      if (bus_if.nv_addr === 2'd2)    m_nv2[rel] = 1'b1;
      if (bus_if.err === 1'b1)        m_err[rel] = 1'b1;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      ws = -1; acc = -1; err_at = -1; m_result = 16'h0000;
    end else begin
      if (run_at(5)) m_result = bus_if.dst;
      if (exp_rdy() && bus_if.strt) begin
        ws = t + 1;
      end else if (ws >= 0 && t > ws && bus_if.cnv_cmplt) begin
        acc = t; ws = -1;
      end
`ifdef TEMP_CAL_TIMEOUT_EN
      else if (ws >= 0 && (t - ws + 1) >= TO) begin
        err_at = t + 1; ws = -1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_outputs();
    @(posedge clk);
    model_advance();
    t++;
    #1;
  endtask

  task automatic clear_marks();
    base = t;
    m_en = '0; m_a2d = '0; m_vld = '0; m_nv1 = '0; m_nv2 = '0; m_err = '0;
  endtask

  task automatic drive(bit s, bit c, bit r);
    bus_if.strt      = s;
    bus_if.cnv_cmplt = c;
    bus_if.dst       = 16'($urandom);
    rst              = r;
  endtask

  initial begin
    t = 0; ws = -1; acc = -1; err_at = -1; base = -100; m_result = 16'h0;
    n_vec = 0; n_err = 0; chk_en = 0;
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // Idle after reset: nothing may move.
    clear_marks();
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
    check("idle_vld_mask", m_vld, 32'h0);
    check("idle_en_mask", m_en, 32'h0);

    // strt at 0, cnv_cmplt at 5, dst = 0x1234 in the ADD2 cycle.
    clear_marks();
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, i == 5, 1'b0);
      if (i == 10) bus_if.dst = 16'h1234;
      tick();
    end
    check("d1_a2d_mask", m_a2d, 32'h0000_0002);
    check("d1_en_mask",  m_en,  32'h0000_0540);
    check("d1_nv1_mask", m_nv1, 32'h0000_0180);
    check("d1_nv2_mask", m_nv2, 32'h0000_0600);
    check("d1_vld_mask", m_vld, 32'h0000_0800);
    check("d1_result", {16'd0, bus_if.result}, 32'h1234);
    check("model_result_pin", {16'd0, m_result}, 32'h1234);

    // cnv_cmplt held high; stale in the a2d_strt cycle, accepted the cycle after.
    clear_marks();
    for (int i = 0; i < 12; i++) begin drive(i == 2, 1'b1, 1'b0); tick(); end
    check("d2_a2d_mask", m_a2d, 32'h0000_0008);
    check("d2_en_mask",  m_en,  32'h0000_02A0);
    check("d2_vld_mask", m_vld, 32'h0000_0400);

    // strt in MUL1/FETCH2 ignored; strt in the result_vld cycle accepted.
    clear_marks();
    for (int i = 0; i < 20; i++) begin
      drive(i == 0 || i == 5 || i == 6 || i == 8, i == 2 || i == 11, 1'b0);
      tick();
    end
    check("d3_a2d_mask", m_a2d, 32'h0000_0202);
    check("d3_vld_mask", m_vld, 32'h0002_0100);

    // Reset during MUL1.
    clear_marks();
    for (int i = 0; i < 10; i++) begin drive(i == 0, i == 2, i == 5); tick(); end
    check("d4_en_mask",  m_en,  32'h0000_0028);
    check("d4_vld_mask", m_vld, 32'h0);
    check("d4_result", {16'd0, bus_if.result}, 32'h0);

`ifdef TEMP_CAL_TIMEOUT_EN
    clear_marks();
    for (int i = 0; i < 14; i++) begin drive(i == 0, 1'b0, 1'b0); tick(); end
    check("to_err_mask", m_err, 32'h0000_0200);
    check("to_rdy", {31'd0, bus_if.rdy}, 32'h1);
    check("to_result", {16'd0, bus_if.result}, 32'h0);
`endif

    // Random traffic against the model.
    base = -100;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
